// File: rtl/multi_way_light_ctrl.sv
// multi_way_light_ctrl: demand-driven round-robin traffic light controller for N_WAYS approaches
module multi_way_light_ctrl #(
    parameter int N_WAYS      = 4,
    parameter int TIMER_WIDTH = 5,
    localparam int AW         = $clog2(N_WAYS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_WAYS-1:0]      car_present,
    input  logic [TIMER_WIDTH-1:0] min_green_value,
    input  logic [TIMER_WIDTH-1:0] max_green_value,
    input  logic [TIMER_WIDTH-1:0] yellow_value,
    input  logic [TIMER_WIDTH-1:0] all_red_value,
    output logic [2*N_WAYS-1:0]    lights,
    output logic [AW-1:0]          active_way,
    output logic [1:0]             phase,
    output logic                   new_green
);
    localparam logic [1:0] PH_GREEN   = 2'd0;
    localparam logic [1:0] PH_YELLOW  = 2'd1;
    localparam logic [1:0] PH_ALL_RED = 2'd2;
    localparam logic [1:0] LT_RED     = 2'd2;

    logic [1:0]             r_phase, w_phase_nxt;
    logic [AW-1:0]          r_active, r_next_way, w_active_nxt, w_next_nxt, w_pick, w_idx;
    logic [TIMER_WIDTH-1:0] r_timer;
    logic [2*N_WAYS-1:0]    r_lights, w_lights_nxt;
    logic                   r_new_green, w_req, w_enter;

    // scan from the farthest way back to the nearest so the nearest requester wins
    always_comb begin
        w_req  = |(car_present & ~(N_WAYS'(1) << r_active));
        w_pick = r_active;
        w_idx  = r_active;
        for (int k = N_WAYS - 1; k >= 1; k--) begin
            w_idx = AW'((int'(r_active) + k) % N_WAYS);
            if (car_present[w_idx]) w_pick = w_idx;
        end
    end

    always_comb begin
        w_phase_nxt  = r_phase;
        w_active_nxt = r_active;
        w_next_nxt   = r_next_way;
        w_enter      = 1'b0;
        case (r_phase)
            PH_GREEN:
                if (w_req && (r_timer >= max_green_value ||
                              (!car_present[r_active] && r_timer >= min_green_value))) begin
                    w_phase_nxt = PH_YELLOW;
                    w_next_nxt  = w_pick;
                    w_enter     = 1'b1;
                end
            PH_YELLOW:
                if (r_timer >= yellow_value) begin
                    w_phase_nxt = PH_ALL_RED;
                    w_enter     = 1'b1;
                end
            PH_ALL_RED:
                if (r_timer >= all_red_value) begin
                    w_phase_nxt  = PH_GREEN;
                    w_active_nxt = r_next_way;
                    w_enter      = 1'b1;
                end
            default: begin
                w_phase_nxt = PH_ALL_RED;
                w_enter     = 1'b1;
            end
        endcase
        // light codes for GREEN/YELLOW coincide with the phase codes
        w_lights_nxt = {N_WAYS{LT_RED}};
        for (int i = 0; i < N_WAYS; i++)
            w_lights_nxt[2*i +: 2] = (w_phase_nxt != PH_ALL_RED && w_active_nxt == AW'(i)) ? w_phase_nxt : LT_RED;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_phase     <= PH_GREEN;
            r_active    <= '0;
            r_next_way  <= '0;
            r_timer     <= '0;
            r_lights    <= {{(N_WAYS-1){LT_RED}}, PH_GREEN};
            r_new_green <= 1'b1;
        end else begin
            r_phase     <= w_phase_nxt;
            r_active    <= w_active_nxt;
            r_next_way  <= w_next_nxt;
            r_timer     <= w_enter ? '0 : (&r_timer ? r_timer : r_timer + 1'b1);
            r_lights    <= w_lights_nxt;
            r_new_green <= w_enter && w_phase_nxt == PH_GREEN;
        end
    end

    assign lights     = r_lights;
    assign active_way = r_active;
    assign phase      = r_phase;
    assign new_green  = r_new_green;
endmodule

// File: doc/multi_way_light_ctrl.md
MULTI_WAY_LIGHT_CTRL -- requirements
Module: multi_way_light_ctrl

Interface
REQ-001 The block SHALL have parameter N_WAYS, default 4: number of approaches, legal range 2..8.
REQ-002 The block SHALL have parameter TIMER_WIDTH, default 5: width of the phase timer and duration inputs.
REQ-003 Port clk, input, 1 bit: single clock; all state SHALL change on its rising edge.
REQ-004 Port reset, input, 1 bit: reset SHALL be synchronous and active-high.
REQ-005 Port car_present, input, N_WAYS bits: bit i high means a car is waiting or present on way i.
REQ-006 Port min_green_value, input, TIMER_WIDTH bits: minimum green timer count.
REQ-007 Port max_green_value, input, TIMER_WIDTH bits: green timer count after which a contested green ends.
REQ-008 Port yellow_value, input, TIMER_WIDTH bits: yellow exit count.
REQ-009 Port all_red_value, input, TIMER_WIDTH bits: all-red clearance exit count.
REQ-010 Port lights, output, 2*N_WAYS bits: lights[2i+1:2i] is the light for way i, encoded GREEN=2'd0, YELLOW=2'd1, RED=2'd2; 2'd3 SHALL never be driven.
REQ-011 Port active_way, output, clog2(N_WAYS) bits: index of the way currently owning GREEN, YELLOW or most recent clearance.
REQ-012 Port phase, output, 2 bits: 0=GREEN, 1=YELLOW, 2=ALL_RED.
REQ-013 Port new_green, output, 1 bit: one-cycle pulse in the first cycle of every GREEN phase.

Function
REQ-014 The phase timer SHALL clear to 0 on every phase entry, increment by 1 each cycle, and saturate at all-ones.
REQ-015 Duration inputs SHALL be sampled every cycle; exit comparisons SHALL use ">=" against the timer.
REQ-016 A request SHALL exist when any car_present bit other than active_way is high.
REQ-017 GREEN SHALL move to YELLOW when a request exists and either timer>=max_green_value, or car_present[active_way]==0 and timer>=min_green_value.
REQ-018 If min_green_value>max_green_value, max_green_value SHALL govern.
REQ-019 With no request, GREEN SHALL hold indefinitely; the timer saturates.
REQ-020 On the GREEN->YELLOW transition, next_way SHALL be latched as the first requesting way in circular order active_way+1, active_way+2, ..., wrapping modulo N_WAYS.
REQ-021 car_present changes during YELLOW or ALL_RED SHALL NOT alter the latched next_way.
REQ-022 YELLOW SHALL move to ALL_RED when timer>=yellow_value; a value of 0 gives 1 yellow cycle.
REQ-023 ALL_RED SHALL move to GREEN on next_way when timer>=all_red_value. active_way SHALL update in that same transition, and new_green SHALL pulse.
REQ-024 In GREEN or YELLOW, only way active_way SHALL be non-RED. In ALL_RED, all ways SHALL be RED.
REQ-025 All outputs SHALL be registered; lights, phase and active_way SHALL reflect the current phase with no combinational path from car_present.
REQ-026 Fairness: a way with car_present held high SHALL get GREEN within (N_WAYS-1) full cycles of the other ways.

Reset
REQ-027 While reset is high at a clock edge: phase=GREEN, active_way=0, timer=0, next_way=0, way 0 GREEN, all other ways RED.
REQ-028 new_green SHALL be high in the first cycle after reset deasserts, since way 0 enters GREEN.
REQ-029 Reset asserted in any phase SHALL abort that phase immediately at the edge, with no yellow or all-red sequence.

Verification
Common setup for all scenarios: N_WAYS=4, min=2, max=5, yellow=1, all_red=0.
REQ-030 car_present=0 for 50 cycles after reset -> way 0 GREEN throughout; the timer saturates at 31.
REQ-031 car_present=4'b0100 held from reset -> way 0 GREEN for 3 cycles, YELLOW for 2, ALL_RED for 1, then way 2 GREEN with a new_green pulse.
REQ-032 car_present=4'b0101 held -> way 0 GREEN for 6 cycles (max), then way 2. Way 2 GREEN for 6 cycles, then way 0. The two ways alternate indefinitely.
REQ-033 car_present=4'b1110 with way 0 GREEN -> the GREEN order is 1, 2, 3, 1 (circular wrap, way 0 skipped).
REQ-034 During way-1 YELLOW (latched next_way=2), change car_present to 4'b1000 -> way 2 still gets GREEN next.
REQ-035 Assert reset during ALL_RED -> the next cycle shows way 0 GREEN and others RED. The bench SHALL also check REQ-024 and the "no 2'd3" rule every cycle.
